piso_shift_n: RTL and testbench

Parallel-in/serial-out shifter downstream of the N-bit write-enabled register. It captures the register's parallel output word on a one-cycle load strobe, then emits the word LSB-first, one bit per clock, with a bit-valid qualifier and an end-of-word pulse. Loads that arrive while a word is shifting are ignored. It is the serial egress stage for register contents.

---
 rtl/piso_shift_n.sv | 130 +++++++++++++
 tb/tb_piso_shift_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_n.sv
// piso_shift_n: parallel-in/serial-out egress shifter, LSB first.
// Captures data_in on an accepted ld strobe and emits one bit per clock.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous reset, active-low
//   data_in  - N-bit parallel word
//   ld       - load strobe, accepted only while ready=1
//   ready    - high in IDLE, when a load will be accepted
//   busy     - high while a word (and parity bit) is being emitted
//   sout     - registered serial data bit
//   sout_vld - high in every cycle sout carries a valid bit
//   done     - one-cycle pulse with the final emitted bit
module piso_shift_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         ld,
    output logic         ready,
    output logic         busy,
    output logic         sout,
    output logic         sout_vld,
    output logic         done
);

    localparam int CW = $clog2(N);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t         state_q;
    logic [N-1:0]   shreg_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           sout_q;
    logic           vld_q;
    logic           done_q;
`ifdef PISO_PARITY_EN
    logic           par_q;
`endif

    assign cnt_d = cnt_q - CW'(1);

    // Single FSM block; sout/sout_vld/done are registered.
    // The cycle carrying done is still a busy cycle, so the FSM
    // lingers one extra edge (cnt==0 in SHIFT, done_q in PARITY)
    // before returning to IDLE; a load is never accepted while done=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ld) begin
                        sout_q  <= data_in[0];
                        shreg_q <= data_in >> 1;
                        cnt_q   <= CW'(N - 1);
                        vld_q   <= 1'b1;
                        state_q <= SHIFT;
`ifdef PISO_PARITY_EN
                        par_q   <= ^data_in;
`endif
                    end else begin
                        sout_q <= 1'b0;
                        vld_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        // Done cycle over: drop the valid qualifier.
                        sout_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        sout_q  <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_d;
                        vld_q   <= 1'b1;
                        if (cnt_q == CW'(1)) begin
`ifdef PISO_PARITY_EN
                            state_q <= PARITY;
`else
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (!done_q) begin
                        sout_q <= par_q;
                        vld_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        sout_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign sout     = sout_q;
    assign sout_vld = vld_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_shift_n.sv
// tb_piso_shift_n: directed, table-driven bench for piso_shift_n.
// Covers N=8 words, ignored loads, back-to-back, reset mid-word, N=4.
module tb_piso_shift_n;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = '0;
    logic       ld = 1'b0;
    logic       ready, busy, sout, sout_vld, done;

    logic [3:0] d4 = '0;
    logic       ld4 = 1'b0;
    logic       ready4, busy4, sout4, vld4, done4;

    int vecs = 0;
    int errs = 0;

    piso_shift_n #(.N(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld),
        .ready(ready), .busy(busy), .sout(sout),
        .sout_vld(sout_vld), .done(done)
    );

    piso_shift_n #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(d4), .ld(ld4),
        .ready(ready4), .busy(busy4), .sout(sout4),
        .sout_vld(vld4), .done(done4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [7:0] seq;
        logic       par;
        int         inj;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // seq holds the emission order with the first bit in seq[7].
    task automatic run_word(input logic [7:0] w, input logic [7:0] seq,
                            input logic p, input int inj);
        chk("ready_pre", ready, 1'b1);
        data_in = w;
        ld = 1'b1;
        tick();
        ld = 1'b0;
        data_in = ~w;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            ld = (i == inj);
            data_in = (i == inj) ? 8'hFF : ~w;
            chk($sformatf("bit%0d", i), sout, seq[7-i]);
            chk($sformatf("vld%0d", i), sout_vld, 1'b1);
            chk($sformatf("done%0d", i), done, (i == 7) && !PAR);
            chk($sformatf("ready%0d", i), ready, 1'b0);
            chk($sformatf("busy%0d", i), busy, 1'b1);
        end
`ifdef PISO_PARITY_EN
        tick();
        ld = 1'b0;
        chk("par_bit", sout, p);
        chk("par_vld", sout_vld, 1'b1);
        chk("par_done", done, 1'b1);
        chk("par_ready", ready, 1'b0);
`else
        chk("par_unused", p | ~p, 1'b1);
`endif
        tick();
        ld = 1'b0;
        chk("post_ready", ready, 1'b1);
        chk("post_busy", busy, 1'b0);
        chk("post_vld", sout_vld, 1'b0);
        chk("post_done", done, 1'b0);
        chk("post_sout", sout, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'b10100101, 1'b0, -1};
        tbl[1] = '{8'h3C, 8'b00111100, 1'b0, 4};
        tbl[2] = '{8'h07, 8'b11100000, 1'b1, -1};
        tbl[3] = '{8'h12, 8'b01001000, 1'b0, 7};
        tbl[4] = '{8'hF0, 8'b00001111, 1'b0, -1};

        rst = 1'b0;
        tick();
        tick();
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sout", sout, 1'b0);
        chk("rst_vld", sout_vld, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_word(tbl[v].word, tbl[v].seq, tbl[v].par, tbl[v].inj);
            tick();
        end

        // Back-to-back: ld held high, 0x01 then 0x80.
        data_in = 8'h01;
        ld = 1'b1;
        tick();
        data_in = 8'h80;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("b2b_a%0d", i), sout, (i == 0));
            chk($sformatf("b2b_av%0d", i), sout_vld, 1'b1);
        end
        chk("b2b_adone", done, !PAR);
        if (PAR) begin
            tick();
            chk("b2b_apar", sout, 1'b1);
            chk("b2b_apdone", done, 1'b1);
        end
        tick();
        chk("b2b_gap_vld", sout_vld, 1'b0);
        chk("b2b_gap_ready", ready, 1'b1);
        tick();
        ld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("b2b_b%0d", i), sout, (i == 7));
            chk($sformatf("b2b_bv%0d", i), sout_vld, 1'b1);
        end
        chk("b2b_bdone", done, !PAR);
        if (PAR) begin
            tick();
            chk("b2b_bpar", sout, 1'b1);
        end
        tick();
        chk("b2b_end_ready", ready, 1'b1);
        tick();

        // Reset mid-word: 0xFF, reset after 3 bits.
        data_in = 8'hFF;
        ld = 1'b1;
        tick();
        ld = 1'b0;
        tick();
        tick();
        chk("mid_bit2", sout, 1'b1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_sout", sout, 1'b0);
        chk("mid_vld", sout_vld, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_ready", ready, 1'b1);
        chk("mid_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) rst = 1'b1;
            chk($sformatf("mid_nodone%0d", i), done, 1'b0);
            chk($sformatf("mid_novld%0d", i), sout_vld, 1'b0);
        end

        // Width check on the N=4 instance: 4'b1001.
        d4 = 4'b1001;
        ld4 = 1'b1;
        tick();
        ld4 = 1'b0;
        d4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("n4_bit%0d", i), sout4, (i == 0) || (i == 3));
            chk($sformatf("n4_vld%0d", i), vld4, 1'b1);
            chk($sformatf("n4_done%0d", i), done4, (i == 3) && !PAR);
        end
        if (PAR) begin
            tick();
            chk("n4_par", sout4, 1'b0);
            chk("n4_pdone", done4, 1'b1);
        end
        tick();
        chk("n4_ready", ready4, 1'b1);
        chk("n4_end_vld", vld4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
